// File: rtl/button_bank_conditioner_if.sv
// Button bank signal bundle: raw buttons and repeat enables in, conditioned
// levels and event pulses out, one bit per channel.
interface button_bank_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn;
  logic [CHANNELS-1:0] repeat_en;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] rpt;

  modport master (
    output btn, repeat_en,
    input  level, press, release_pulse, rpt
  );

  modport slave (
    input  btn, repeat_en,
    output level, press, release_pulse, rpt
  );
endinterface

// File: rtl/button_bank_conditioner.sv
// Multi-channel push-button front end: synchroniser, debounce, press/release
// pulses, post-release press lockout and hold-to-repeat, one lane per channel.
module button_bank_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LOCKOUT_CYCLES  = 16777216,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LCK_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HELD, HELD_MUTED, LOCKOUT} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_W-1:0]       deb_cnt, deb_nxt;
  logic [LCK_W-1:0]       lck_cnt, lck_nxt;
  logic [RPT_W-1:0]       rpt_cnt, rpt_cnt_nxt;
  logic                   phase, phase_nxt;
  logic                   level_nxt, rise, fall, s;
  logic                   press_nxt, rel_nxt, rpt_nxt;
  state_t                 state, state_nxt;

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce: the level flips on the same edge the FSM sees rise/fall.
  always_comb begin
    deb_nxt   = deb_cnt;
    level_nxt = level;
    rise      = 1'b0;
    fall      = 1'b0;
    if (s == level) begin
      deb_nxt = '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_nxt   = '0;
      level_nxt = s;
      rise      = s;
      fall      = !s;
    end else begin
      deb_nxt = deb_cnt + DEB_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    lck_nxt     = '0;
    rpt_cnt_nxt = '0;
    phase_nxt   = 1'b0;
    press_nxt   = 1'b0;
    rel_nxt     = 1'b0;
    rpt_nxt     = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_nxt = HELD;
        press_nxt = 1'b1;
      end
      HELD: begin
        if (fall) begin
          rel_nxt   = 1'b1;
          state_nxt = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
        end else if (repeat_en) begin
          // phase 0 waits the initial delay, phase 1 runs the period
          phase_nxt   = phase;
          rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
          if (!phase && rpt_cnt == DLY_LAST) begin
            rpt_nxt     = 1'b1;
            rpt_cnt_nxt = '0;
            phase_nxt   = 1'b1;
          end else if (phase && rpt_cnt == PER_LAST) begin
            rpt_nxt     = 1'b1;
            rpt_cnt_nxt = '0;
          end
        end
      end
      HELD_MUTED: if (fall) begin
        rel_nxt   = 1'b1;
        state_nxt = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
      end
      LOCKOUT: begin
        if (rise)                      state_nxt = HELD_MUTED;
        else if (lck_cnt == LCK_LAST)  state_nxt = IDLE;
        else                           lck_nxt   = lck_cnt + LCK_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= '0;
      deb_cnt       <= '0;
      lck_cnt       <= '0;
      rpt_cnt       <= '0;
      phase         <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      rpt           <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], btn};
      deb_cnt       <= deb_nxt;
      lck_cnt       <= lck_nxt;
      rpt_cnt       <= rpt_cnt_nxt;
      phase         <= phase_nxt;
      level         <= level_nxt;
      press         <= press_nxt;
      release_pulse <= rel_nxt;
      rpt           <= rpt_nxt;
    end
  end
endmodule

module button_bank_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LOCKOUT_CYCLES  = 16777216,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  button_bank_conditioner_if.slave     bus
);
  logic [CHANNELS-1:0] level, press, rel, rpt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    button_bank_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (bus.btn[i]),
      .repeat_en    (bus.repeat_en[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(rel[i]),
      .rpt          (rpt[i])
    );
  end

  assign bus.level         = level;
  assign bus.press         = press;
  assign bus.release_pulse = rel;
  assign bus.rpt           = rpt;
endmodule

// File: doc/button_bank_conditioner.md
# button_bank_conditioner

Multi-channel button front end: per-channel synchroniser, counter-based debounce, registered press/release pulses, post-release lockout, and optional auto-repeat. It sits between the board push-buttons and the game/menu control logic. It is the generalised replacement for single-button edge conditioning, adding channel count, a configurable debounce window, release pulses and hold-to-repeat.

## Interface

- CHANNELS, 4: number of independent button channels (≥1).
- SYNC_STAGES, 2: synchroniser flop count (≥2).
- DEBOUNCE_CYCLES, 65536: consecutive cycles a new synchronised level must persist before it is accepted (≥1).
- LOCKOUT_CYCLES, 16777216: press-suppression window after a release (0 = no lockout).
- REPEAT_DELAY, 50000000: cycles from the press edge to the first repeat pulse (≥1).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses (≥1).

Ports:

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn  in  CHANNELS  raw asynchronous button levels, active high.
- repeat_en  in  CHANNELS  per-channel auto-repeat enable, synchronous to clk.
- level  out  CHANNELS  debounced button state.
- press  out  CHANNELS  one-cycle pulse on an accepted press.
- release  out  CHANNELS  one-cycle pulse on every debounced fall.
- rpt  out  CHANNELS  one-cycle auto-repeat pulse.

## Operation

- Channels are fully independent. All outputs are registered.
- **Synchroniser:** btn[i] passes through SYNC_STAGES flops; s is the last stage.
- **Debounce:**
  - If s == level, the counter is cleared.
  - Else, if the counter == DEBOUNCE_CYCLES-1, then level <= s and the counter is cleared.
  - Else the counter increments.
  - Any return of s to level before acceptance clears the counter.
- **Per-channel FSM:** IDLE, HELD, HELD_MUTED, LOCKOUT.
  - IDLE, level rises: go to HELD and assert press.
  - LOCKOUT, level rises: go to HELD_MUTED. No press. The lockout counter is abandoned.
  - HELD or HELD_MUTED, level falls: assert release. Go to LOCKOUT with the lockout counter at 0. If LOCKOUT_CYCLES == 0, go to IDLE instead.
  - LOCKOUT: the counter increments each cycle. At LOCKOUT_CYCLES-1 go to IDLE.
- **Repeat (HELD only):**
  - The repeat counter and phase are cleared on the press edge and in every cycle that repeat_en[i] is low.
  - While repeat_en[i] is high, the counter increments.
  - Delay phase: at REPEAT_DELAY-1, assert rpt, clear the counter and enter the periodic phase.
  - Periodic phase: assert rpt at REPEAT_PERIOD-1, then clear the counter.
  - Re-enabling mid-hold restarts from the delay phase.
  - HELD_MUTED never asserts rpt.
- **Simultaneous events:**
  - release has priority; no rpt on the release edge.
  - press, release and rpt are mutually exclusive per channel per cycle.
- **Counter widths:** $clog2 of the respective parameter, minimum 1 bit. Counters never wrap; each is cleared at its terminal value.

## Timing

- **Reset:**
  - Takes effect on a clk edge with rst_n low.
  - All synchroniser flops, level, press, release and rpt go to 0.
  - All counters go to 0; all FSMs go to IDLE.
  - Reset mid-hold or mid-lockout discards that state.
  - A button still held when reset ends is treated as a fresh press: press fires after the normal latency.
- **Latency:** with btn[i] first sampled high at edge 0 and held steady, level[i] and press[i] rise at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. Release latency is identical.
- press, release and rpt are high for exactly one cycle and are asserted on the same edge as the corresponding level change or counter terminal value.
- **First repeat:** edge (press edge)+REPEAT_DELAY, then every REPEAT_PERIOD edges, provided repeat_en is held high from the press edge.
- **Lockout window:** a level rise within LOCKOUT_CYCLES edges after the release edge is muted. A rise at release edge + LOCKOUT_CYCLES+1 or later is a normal press.

## Test plan

Parameters for all scenarios: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, REPEAT_DELAY=10, REPEAT_PERIOD=3.

- **Clean press:** btn[0]=1 from edge 0 -> level[0] and press[0] rise at edge 5; press[0] falls at edge 6; channel 1 outputs stay 0.
- **Bounce rejection:** btn[0] toggles with high/low runs of 1–3 cycles for 50 cycles -> level, press and release stay 0. A final steady high -> press 5 edges after it starts.
- **Lockout:** press, then release (release pulse) -> btn re-pressed so level rises 4 edges after the release edge.
  - Required: level=1, press=0, and no rpt while held with repeat_en=1.
  - The second release gives a release pulse and restarts lockout.
  - A press 9+ edges after that gives press.
- **Auto-repeat:** repeat_en[1]=1 and hold ch1 -> rpt[1] at press edge+10, +13, +16.
  - Dropping repeat_en for 2 cycles stops rpt; re-enabling gives the next rpt 10 edges later.
  - Release gives release[1] and no further rpt.
- **Reset mid-operation:** rst_n=0 for 1 edge during a hold with btn held -> all outputs 0 on that edge; press re-fires 5 edges after the first edge with rst_n=1.
- **Corners:** DEBOUNCE_CYCLES=1 and LOCKOUT_CYCLES=0 -> level follows btn 2 edges late. Every rise gives press and every fall gives release, including back-to-back toggles.
